can_form_checker: RTL

//  Parametrised successor of the CAN form-error monitor. Checks fixed-form bits (SRR, CRC delim,
//  ACK delim, EOF) at each bit sample point. Tracks EOF bit position and reports one error per frame.

---
 rtl/can_frame_pkg.sv | 19 +
 rtl/can_eof_bit_counter.sv | 29 ++
 rtl/can_form_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/can_frame_pkg.sv
// Shared CAN frame definitions: field codes, EOF length and form-checker FSM encoding.
// Used by the bit-stream decoder, the form checker and the error-frame generator.
package can_frame_pkg;

  localparam int CAN_FIELD_W       = 5;
  localparam int CAN_FIELD_IDLE    = 0;
  localparam int CAN_FIELD_EOF     = 5;
  localparam int CAN_FIELD_SRR     = 8;
  localparam int CAN_FIELD_CRC_DEL = 17;
  localparam int CAN_FIELD_ACK_DEL = 18;
  localparam int CAN_EOF_LEN       = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_SUPPRESS = 2'd2
  } form_state_e;

endpackage

// File: rtl/can_eof_bit_counter.sv
// Saturating End-Of-Frame bit index; cleared by the first sample taken outside EOF.
module can_eof_bit_counter
  import can_frame_pkg::*;
#(
  parameter int EOF_LEN = CAN_EOF_LEN
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_step,
  input  logic       i_is_eof,
  output logic [2:0] o_idx
);

  localparam logic [2:0] IDX_LAST = 3'(EOF_LEN - 1);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_idx <= 3'd0;
    end else if (i_step) begin
      if (!i_is_eof)
        o_idx <= 3'd0;
      else if (o_idx != IDX_LAST)
        o_idx <= o_idx + 3'd1;
    end
  end

endmodule

// File: rtl/can_form_checker.sv
// CAN form-error monitor: checks fixed-form bits, one error per frame, sticky status.
// Optional saturating error counter built only when CAN_FORM_ERR_CNT_EN is defined.
module can_form_checker
  import can_frame_pkg::*;
#(
  parameter int FIELD_W         = CAN_FIELD_W,
  parameter int FIELD_IDLE      = CAN_FIELD_IDLE,
  parameter int FIELD_EOF       = CAN_FIELD_EOF,
  parameter int FIELD_SRR       = CAN_FIELD_SRR,
  parameter int FIELD_CRC_DEL   = CAN_FIELD_CRC_DEL,
  parameter int FIELD_ACK_DEL   = CAN_FIELD_ACK_DEL,
  parameter int EOF_LEN         = CAN_EOF_LEN,
  parameter int EOF_LAST_IGNORE = 1,
  parameter int CNT_W           = 8
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_sample,
  input  logic               i_Data,
  input  logic [FIELD_W-1:0] i_frame_field,
  input  logic               i_clear,
  output logic               o_form_monitor,
  output logic               o_form_err,
  output logic [FIELD_W-1:0] o_err_field,
  output logic [2:0]         o_eof_bit_idx,
  output logic [CNT_W-1:0]   o_err_count
);

  localparam logic [FIELD_W-1:0] F_IDLE = FIELD_W'(FIELD_IDLE);
  localparam logic [FIELD_W-1:0] F_EOF  = FIELD_W'(FIELD_EOF);
  localparam logic [FIELD_W-1:0] F_SRR  = FIELD_W'(FIELD_SRR);
  localparam logic [FIELD_W-1:0] F_CRC  = FIELD_W'(FIELD_CRC_DEL);
  localparam logic [FIELD_W-1:0] F_ACK  = FIELD_W'(FIELD_ACK_DEL);
  localparam logic [2:0]         IDX_LAST = 3'(EOF_LEN - 1);

  generate
    if (EOF_LEN < 1 || EOF_LEN > 8) begin : g_eof_len_check
      $error("can_form_checker: EOF_LEN must be in 1..8 for a 3-bit index");
    end
  endgenerate

  logic               s1_sample;
  logic               s1_data;
  logic [FIELD_W-1:0] s1_field;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s1_sample <= 1'b0;
      s1_data   <= 1'b0;
      s1_field  <= '0;
    end else begin
      s1_sample <= i_sample;
      s1_data   <= i_Data;
      s1_field  <= i_frame_field;
    end
  end

  logic       s1_is_eof;
  logic [2:0] eof_idx;

  assign s1_is_eof = (s1_field == F_EOF);

  can_eof_bit_counter #(
    .EOF_LEN (EOF_LEN)
  ) u_eof_cnt (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_step   (s1_sample),
    .i_is_eof (s1_is_eof),
    .o_idx    (eof_idx)
  );

  form_state_e state, state_nxt;
  logic        is_checked;
  logic        last_ignored;
  logic        form_err;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    is_checked   = (s1_field == F_SRR) || (s1_field == F_CRC) ||
                   (s1_field == F_ACK) || s1_is_eof;
    last_ignored = (EOF_LAST_IGNORE != 0) && s1_is_eof && (eof_idx == IDX_LAST);
    form_err     = s1_sample && (state == ST_ACTIVE) && is_checked &&
                   !s1_data && !last_ignored;
    if (s1_sample) begin
      unique case (state)
        ST_IDLE:     if (s1_field != F_IDLE) state_nxt = ST_ACTIVE;
        ST_ACTIVE:   if (form_err) state_nxt = ST_SUPPRESS;
                     else if (s1_field == F_IDLE) state_nxt = ST_IDLE;
        ST_SUPPRESS: if (s1_field == F_IDLE) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // A new error outranks a coincident clear, and replaces the stored field in that case.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_form_monitor <= 1'b0;
      o_form_err     <= 1'b0;
      o_err_field    <= '0;
      o_eof_bit_idx  <= 3'd0;
    end else begin
      o_form_monitor <= form_err;
      if (s1_sample)
        o_eof_bit_idx <= s1_is_eof ? eof_idx : 3'd0;
      if (form_err) begin
        o_form_err <= 1'b1;
        if (!o_form_err || i_clear)
          o_err_field <= s1_field;
      end else if (i_clear) begin
        o_form_err  <= 1'b0;
        o_err_field <= '0;
      end
    end
  end

`ifdef CAN_FORM_ERR_CNT_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      o_err_count <= '0;
    else if (form_err && (o_err_count != {CNT_W{1'b1}}))
      o_err_count <= o_err_count + CNT_W'(1);
  end
`else
  assign o_err_count = '0;
`endif

endmodule
